// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: command codes, FSM states and NZCV bit positions.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 32;
    localparam int unsigned ALU_CMD_W  = 4;

    localparam logic [ALU_CMD_W-1:0] CMD_MOV = 4'b0001;
    localparam logic [ALU_CMD_W-1:0] CMD_ADD = 4'b0010;
    localparam logic [ALU_CMD_W-1:0] CMD_ADC = 4'b0011;
    localparam logic [ALU_CMD_W-1:0] CMD_SUB = 4'b0100;
    localparam logic [ALU_CMD_W-1:0] CMD_SBC = 4'b0101;
    localparam logic [ALU_CMD_W-1:0] CMD_AND = 4'b0110;
    localparam logic [ALU_CMD_W-1:0] CMD_ORR = 4'b0111;
    localparam logic [ALU_CMD_W-1:0] CMD_EOR = 4'b1000;
    localparam logic [ALU_CMD_W-1:0] CMD_MVN = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

    function automatic logic cmd_legal(input logic [ALU_CMD_W-1:0] cmd);
        return (cmd >= CMD_MOV) && (cmd <= CMD_MVN);
    endfunction

endpackage

// File: rtl/alu_flag_unit.sv
// Next-value NZCV logic for one executed ALU operation.
module alu_flag_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W
) (
    input  logic [ALU_CMD_W-1:0] cmd,
    input  logic                 val1_msb,
    input  logic                 val2_msb,
    input  logic [DATA_W-1:0]    result,
    input  logic                 carry,
    input  logic                 s,
    input  logic [3:0]           nzcv,
    output logic [3:0]           nzcv_next_c
);

    logic res_msb;
    assign res_msb = result[DATA_W-1];

    // Logical and move ops only touch N/Z; C/V carry over.
    always_comb begin
        nzcv_next_c = nzcv;
        if (s && cmd_legal(cmd)) begin
            nzcv_next_c[NZCV_N] = res_msb;
            nzcv_next_c[NZCV_Z] = (result == '0);
            if (cmd == CMD_ADD || cmd == CMD_ADC) begin
                nzcv_next_c[NZCV_C] = carry;
                nzcv_next_c[NZCV_V] = (val1_msb == val2_msb) && (res_msb != val1_msb);
            end else if (cmd == CMD_SUB || cmd == CMD_SBC) begin
                nzcv_next_c[NZCV_C] = carry;
                nzcv_next_c[NZCV_V] = (val1_msb != val2_msb) && (res_msb != val1_msb);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter around the shared execute ALU, owning the NZCV status register.
// ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention (default build is round robin).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned CMD_W  = ALU_CMD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CMD_W-1:0]  req0_cmd,
    input  logic [DATA_W-1:0] req0_val1,
    input  logic [DATA_W-1:0] req0_val2,
    input  logic              req0_s,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CMD_W-1:0]  req1_cmd,
    input  logic [DATA_W-1:0] req1_val1,
    input  logic [DATA_W-1:0] req1_val2,
    input  logic              req1_s,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_val1,
    output logic [DATA_W-1:0] alu_val2,
    output logic [CMD_W-1:0]  alu_cmd,
    output logic              alu_carry_in,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry_out,
    output logic [3:0]        status_nzcv
);

    state_t             state;
    state_t             state_nx;
    logic [CMD_W-1:0]   op_cmd;
    logic [DATA_W-1:0]  op_val1;
    logic [DATA_W-1:0]  op_val2;
    logic               op_s;
    logic               op_id;
    logic               grant0_c;
    logic               grant1_c;
    logic               exec_c;
    logic [3:0]         nzcv_next_c;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic               last_grant;
`endif

    // Next state and grant selection.
    always_comb begin
        state_nx = state;
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    grant0_c = 1'b1;
`else
                    grant0_c = last_grant;
                    grant1_c = ~last_grant;
`endif
                end else begin
                    grant0_c = req0_valid;
                    grant1_c = req1_valid;
                end
                if (req0_valid || req1_valid) state_nx = EXEC;
            end
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign req0_ready = grant0_c & ~rst;
    assign req1_ready = grant1_c & ~rst;
    assign rsp_valid  = (state == RESP);

    // ALU lines are only live while the operation executes.
    assign exec_c       = (state == EXEC);
    assign alu_val1     = exec_c ? op_val1 : '0;
    assign alu_val2     = exec_c ? op_val2 : '0;
    assign alu_cmd      = exec_c ? op_cmd  : '0;
    assign alu_carry_in = exec_c & status_nzcv[NZCV_C];

    alu_flag_unit #(.DATA_W(DATA_W)) u_flags (
        .cmd         (op_cmd),
        .val1_msb    (op_val1[DATA_W-1]),
        .val2_msb    (op_val2[DATA_W-1]),
        .result      (alu_out),
        .carry       (alu_carry_out),
        .s           (op_s),
        .nzcv        (status_nzcv),
        .nzcv_next_c (nzcv_next_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_cmd      <= '0;
            op_val1     <= '0;
            op_val2     <= '0;
            op_s        <= 1'b0;
            op_id       <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            status_nzcv <= 4'b0000;
        end else begin
            state <= state_nx;
            if (grant0_c || grant1_c) begin
                op_cmd  <= grant1_c ? req1_cmd  : req0_cmd;
                op_val1 <= grant1_c ? req1_val1 : req0_val1;
                op_val2 <= grant1_c ? req1_val2 : req0_val2;
                op_s    <= grant1_c ? req1_s    : req0_s;
                op_id   <= grant1_c;
            end
            if (exec_c) begin
                rsp_id      <= op_id;
                rsp_data    <= cmd_legal(op_cmd) ? alu_out : '0;
                rsp_err     <= ~cmd_legal(op_cmd);
                status_nzcv <= nzcv_next_c;
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       last_grant <= 1'b1;
        else if (grant0_c || grant1_c) last_grant <= grant1_c;
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a transaction-level arbitration/ALU/flag reference model.
module tb_alu_arbiter;
    import alu_pkg::*;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_s;
    logic [3:0]  req0_cmd;
    logic [31:0] req0_val1, req0_val2;
    logic        req1_valid, req1_ready, req1_s;
    logic [3:0]  req1_cmd;
    logic [31:0] req1_val1, req1_val2;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] alu_val1, alu_val2, alu_out;
    logic [3:0]  alu_cmd;
    logic        alu_carry_in, alu_carry_out;
    logic [3:0]  status_nzcv;
    logic [32:0] env_t;

    int checks = 0;
    int errors = 0;
    logic [3:0] m_nzcv;
    bit         m_lg;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
        .req0_val1(req0_val1), .req0_val2(req0_val2), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
        .req1_val1(req1_val1), .req1_val2(req1_val2), .req1_s(req1_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cmd(alu_cmd),
        .alu_carry_in(alu_carry_in), .alu_out(alu_out), .alu_carry_out(alu_carry_out),
        .status_nzcv(status_nzcv)
    );

    // External execute ALU the arbiter drives.
    always_comb begin
        env_t = '0;
        case (alu_cmd)
            CMD_MOV: env_t = {1'b0, alu_val2};
            CMD_MVN: env_t = {1'b0, ~alu_val2};
            CMD_ADD: env_t = {1'b0, alu_val1} + {1'b0, alu_val2};
            CMD_ADC: env_t = {1'b0, alu_val1} + {1'b0, alu_val2} + 33'(alu_carry_in);
            CMD_SUB: env_t = {1'b0, alu_val1} + {1'b0, ~alu_val2} + 33'd1;
            CMD_SBC: env_t = {1'b0, alu_val1} + {1'b0, ~alu_val2} + 33'(alu_carry_in);
            CMD_AND: env_t = {1'b0, alu_val1 & alu_val2};
            CMD_ORR: env_t = {1'b0, alu_val1 | alu_val2};
            CMD_EOR: env_t = {1'b0, alu_val1 ^ alu_val2};
            default: env_t = {1'b1, 32'hDEAD_BEEF};
        endcase
    end
    assign alu_out       = env_t[31:0];
    assign alu_carry_out = env_t[32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural effect of one operation: signed/unsigned arithmetic on wide integers.
    task automatic model_exec(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                              input logic s, output logic [31:0] r, output logic err);
        longint ua, ub, sa, sb, sv, ci;
        logic   c, v;
        bit     arith;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ci = m_nzcv[1] ? 64'sd1 : 64'sd0;
        sv = 0; c = 1'b0; arith = 1'b0; err = 1'b0; r = '0;
        case (cmd)
            CMD_MOV: r = b;
            CMD_MVN: r = ~b;
            CMD_AND: r = a & b;
            CMD_ORR: r = a | b;
            CMD_EOR: r = a ^ b;
            CMD_ADD: begin r = 32'(ua + ub);      c = (ua + ub) > 64'sd4294967295;      sv = sa + sb;      arith = 1'b1; end
            CMD_ADC: begin r = 32'(ua + ub + ci); c = (ua + ub + ci) > 64'sd4294967295; sv = sa + sb + ci; arith = 1'b1; end
            CMD_SUB: begin r = 32'(ua - ub);      c = ua >= ub;                         sv = sa - sb;      arith = 1'b1; end
            CMD_SBC: begin r = 32'(ua - ub - (1 - ci)); c = ua >= ub + (1 - ci); sv = sa - sb - (1 - ci); arith = 1'b1; end
            default: err = 1'b1;
        endcase
        v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        if (!err && s) begin
            m_nzcv[3] = r[31];
            m_nzcv[2] = (r == 32'd0);
            if (arith) begin
                m_nzcv[1] = c;
                m_nzcv[0] = v;
            end
        end
    endtask

    // One full transaction: present requests, check grant, EXEC lines, response and stall behaviour.
    task automatic issue(input bit v0, input bit v1,
                         input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0, input logic s0,
                         input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1, input logic s1,
                         input int stall);
        bit          w;
        logic [3:0]  c;
        logic [31:0] a, b, r;
        logic        s, err;
        @(negedge clk);
        req0_valid = v0; req0_cmd = c0; req0_val1 = a0; req0_val2 = b0; req0_s = s0;
        req1_valid = v1; req1_cmd = c1; req1_val1 = a1; req1_val2 = b1; req1_s = s1;
        #1;
        if (v0 && v1) w = FIXED ? 1'b0 : ~m_lg;
        else          w = v1;
        check("grant_ready0", 32'(req0_ready), 32'(w == 1'b0));
        check("grant_ready1", 32'(req1_ready), 32'(w == 1'b1));
        m_lg = w;
        c = w ? c1 : c0; a = w ? a1 : a0; b = w ? b1 : b0; s = w ? s1 : s0;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_val1 = ~a0; req1_val1 = ~a1;
        #1;
        check("exec_cmd", 32'(alu_cmd), 32'(c));
        check("exec_val1", alu_val1, a);
        check("exec_val2", alu_val2, b);
        check("exec_cin", 32'(alu_carry_in), 32'(m_nzcv[1]));
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        model_exec(c, a, b, s, r, err);
        @(negedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(w));
        check("rsp_data", rsp_data, r);
        check("rsp_err", 32'(rsp_err), 32'(err));
        check("nzcv", 32'(status_nzcv), 32'(m_nzcv));
        check("resp_alu_cmd", 32'(alu_cmd), 32'd0);
        if (stall > 0) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            #1;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", rsp_data, r);
            check("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("consume_no_grant", 32'({req0_ready, req1_ready}), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] edges [4];
        edges[0] = 32'h0000_0000; edges[1] = 32'h7FFF_FFFF;
        edges[2] = 32'h8000_0000; edges[3] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    function automatic logic [3:0] rand_cmd();
        if ($urandom_range(0, 7) == 0) return ($urandom_range(0, 1) == 0) ? 4'h0 : 4'(10 + $urandom_range(0, 5));
        return 4'(1 + $urandom_range(0, 8));
    endfunction

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_cmd = '0; req0_val1 = '0; req0_val2 = '0; req0_s = 1'b0;
        req1_valid = 1'b0; req1_cmd = '0; req1_val1 = '0; req1_val2 = '0; req1_s = 1'b0;
        m_nzcv = 4'b0000; m_lg = 1'b1;
        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        #1;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_nzcv", 32'(status_nzcv), 32'd0);
        check("rst_alu_cmd", 32'(alu_cmd), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Contention right after reset, then again
        issue(1, 1, CMD_MOV, 32'd5, 32'd5, 1'b0, CMD_MOV, 32'd7, 32'd7, 1'b0, 0);
        issue(1, 1, CMD_MOV, 32'd5, 32'd5, 1'b0, CMD_MOV, 32'd7, 32'd7, 1'b0, 0);
        // Signed overflow into N
        issue(1, 0, CMD_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, CMD_MOV, 32'd0, 32'd0, 1'b0, 0);
        // Zero result with carry, then carry consumed
        issue(1, 0, CMD_SUB, 32'd3, 32'd3, 1'b1, CMD_MOV, 32'd0, 32'd0, 1'b0, 0);
        issue(0, 1, CMD_MOV, 32'd0, 32'd0, 1'b0, CMD_ADC, 32'd1, 32'd1, 1'b0, 1);
        // Establish C=V=1, then logical op keeps them
        issue(1, 0, CMD_ADD, 32'h8000_0000, 32'h8000_0000, 1'b1, CMD_MOV, 32'd0, 32'd0, 1'b0, 0);
        issue(0, 1, CMD_MOV, 32'd0, 32'd0, 1'b0, CMD_AND, 32'hF0, 32'h0F, 1'b1, 0);
        // Illegal command with a long response stall
        issue(0, 1, CMD_MOV, 32'd0, 32'd0, 1'b0, 4'b1111, 32'd9, 32'd9, 1'b1, 4);

        // Reset while an operation is executing
        @(negedge clk);
        req0_valid = 1'b1; req0_cmd = CMD_ADD; req0_val1 = 32'd1; req0_val2 = 32'd2; req0_s = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_alu_cmd", 32'(alu_cmd), 32'd0);
        check("mid_rst_alu_val1", alu_val1, 32'd0);
        check("mid_rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("mid_rst_nzcv", 32'(status_nzcv), 32'd0);
        check("mid_rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        m_nzcv = 4'b0000; m_lg = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        issue(1, 0, CMD_ORR, 32'h0F00, 32'h00F0, 1'b1, CMD_MOV, 32'd0, 32'd0, 1'b0, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            issue(sel[0], sel[1],
                  rand_cmd(), rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                  rand_cmd(), rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
